rv32_mem_stage: RTL and testbench

Fourth pipeline stage of the rv32 core. It consumes `exec_mem_buff` from the exec stage and drives a data-memory request/response bus for loads and stores. It aligns and sign/zero-extends load data, generates store byte enables, and registers the result into `mem_wb_buff` for writeback. It stalls the upstream pipeline while a bus access is outstanding and provides `wb_bypass` to the exec-stage forwarding mux.

---
 rtl/rv32_mem_stage.sv | 218 +++++++++++++++++++++
 tb/tb_rv32_mem_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_stage.sv
//------------------------------------------------------------------------------
// Module   : rv32_mem_stage (with rv32_types package)
// Brief    : rv32 memory stage; data-bus loads/stores, writeback register.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32_types;
  typedef logic [31:0] rv32_word;

  localparam rv32_word RV_NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0, LB, LH, LW, LBU, LHU, SB, SH, SW
  } mem_op_t;

  typedef enum logic [1:0] {WB_NONE = 2'd0, WB_ALU, WB_MEM, WB_STORE} wb_src_t;

  typedef struct packed {
    mem_op_t    mem_op;
    wb_src_t    wb_result_src;
    logic [4:0] rd;
    logic       reg_write;
  } decoded_instr_t;

  typedef struct packed {
    rv32_word       instr;
    rv32_word       pc;
    decoded_instr_t decoded_instr;
    rv32_word       mem_addr;
    rv32_word       wb_result;
  } exec_mem_buffer_t;

  typedef struct packed {
    rv32_word       instr;
    rv32_word       pc;
    decoded_instr_t decoded_instr;
    rv32_word       wb_result;
  } mem_wb_buffer_t;

  function automatic decoded_instr_t create_nop_ctrl();
    decoded_instr_t d;
    d.mem_op        = MEM_NONE;
    d.wb_result_src = WB_NONE;
    d.rd            = 5'd0;
    d.reg_write     = 1'b0;
    return d;
  endfunction
endpackage

module rv32_mem_stage
  import rv32_types::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  exec_mem_buffer_t exec_mem_buff,
  output mem_wb_buffer_t   mem_wb_buff,
  input  logic             stop,
  output logic             mem_stall,
  output rv32_word         wb_bypass,
  output logic             dmem_req,
  output logic             dmem_we,
  output rv32_word         dmem_addr,
  output rv32_word         dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ready,
  input  logic             dmem_rvalid,
  input  rv32_word         dmem_rdata,
  output logic             misaligned
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;

  state_t         r_state;
  logic [1:0]     r_lane;
  mem_op_t        r_ld_op;
  logic           r_done;
  rv32_word       r_rsp_data;

  mem_op_t        w_op;
  rv32_word       w_addr;
  logic           w_is_load;
  logic           w_is_store;
  logic           w_is_half;
  logic           w_is_word;
  logic           w_bus_op;
  logic           w_accept;
  logic           w_store_acc;
  logic           w_load_rsp;
  logic           w_complete;
  logic [3:0]     w_be;
  logic [7:0]     w_ld_byte;
  logic [15:0]    w_ld_half;
  rv32_word       w_load_result;
  mem_wb_buffer_t w_next_wb;

  assign w_op   = exec_mem_buff.decoded_instr.mem_op;
  assign w_addr = exec_mem_buff.mem_addr;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_is_half  = 1'b0;
    w_is_word  = 1'b0;
    case (w_op)
      LB, LBU:  w_is_load = 1'b1;
      LH, LHU:  begin w_is_load = 1'b1;  w_is_half = 1'b1; end
      LW:       begin w_is_load = 1'b1;  w_is_word = 1'b1; end
      SB:       w_is_store = 1'b1;
      SH:       begin w_is_store = 1'b1; w_is_half = 1'b1; end
      SW:       begin w_is_store = 1'b1; w_is_word = 1'b1; end
      default:  ;
    endcase
  end

  assign misaligned = (w_is_half & w_addr[0]) | (w_is_word & (|w_addr[1:0]));
  assign w_bus_op   = (w_is_load | w_is_store) & ~misaligned;

  // r_done: bus part finished while stopped; only the writeback is pending.
  assign dmem_req    = w_bus_op & (r_state == IDLE) & ~r_done;
  assign w_accept    = dmem_req & dmem_ready;
  assign w_store_acc = w_accept & w_is_store;
  assign w_load_rsp  = (r_state == WAIT_RSP) & dmem_rvalid;
  assign w_complete  = w_store_acc | w_load_rsp | r_done;
  assign mem_stall   = w_bus_op & ~w_complete;

  assign dmem_we   = w_is_store;
  assign dmem_addr = {w_addr[31:2], 2'b00};
  assign dmem_be   = dmem_req ? w_be : 4'b0000;
  assign wb_bypass = mem_wb_buff.wb_result;

  always_comb begin
    dmem_wdata = exec_mem_buff.wb_result;
    w_be       = 4'b1111;
    if (w_is_half) begin
      dmem_wdata = {2{exec_mem_buff.wb_result[15:0]}};
      w_be       = w_addr[1] ? 4'b1100 : 4'b0011;
    end else if (!w_is_word) begin
      dmem_wdata = {4{exec_mem_buff.wb_result[7:0]}};
      w_be       = 4'b0001 << w_addr[1:0];
    end
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_ld_byte = dmem_rdata[7:0];
      2'd1:    w_ld_byte = dmem_rdata[15:8];
      2'd2:    w_ld_byte = dmem_rdata[23:16];
      default: w_ld_byte = dmem_rdata[31:24];
    endcase
    w_ld_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_ld_op)
      LB:      w_load_result = {{24{w_ld_byte[7]}}, w_ld_byte};
      LBU:     w_load_result = {24'd0, w_ld_byte};
      LH:      w_load_result = {{16{w_ld_half[15]}}, w_ld_half};
      LHU:     w_load_result = {16'd0, w_ld_half};
      default: w_load_result = dmem_rdata;
    endcase
  end

  // Anything not completing this cycle leaves a bubble so WB never repeats.
  always_comb begin
    w_next_wb.instr         = RV_NOP;
    w_next_wb.pc            = '0;
    w_next_wb.decoded_instr = create_nop_ctrl();
    w_next_wb.wb_result     = '0;
    if ((!w_bus_op && !misaligned) || (w_bus_op && w_complete)) begin
      w_next_wb.instr         = exec_mem_buff.instr;
      w_next_wb.pc            = exec_mem_buff.pc;
      w_next_wb.decoded_instr = exec_mem_buff.decoded_instr;
      w_next_wb.wb_result     = exec_mem_buff.wb_result;
      if (w_bus_op && w_is_load)
        w_next_wb.wb_result = r_done ? r_rsp_data : w_load_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state                   <= IDLE;
      r_lane                    <= 2'd0;
      r_ld_op                   <= MEM_NONE;
      r_done                    <= 1'b0;
      r_rsp_data                <= '0;
      mem_wb_buff.instr         <= RV_NOP;
      mem_wb_buff.pc            <= '0;
      mem_wb_buff.decoded_instr <= create_nop_ctrl();
      mem_wb_buff.wb_result     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_load) begin
            r_state <= WAIT_RSP;
            r_lane  <= w_addr[1:0];
            r_ld_op <= w_op;
          end
        end
        WAIT_RSP: begin
          if (dmem_rvalid)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (stop) begin
        if (w_store_acc || w_load_rsp) begin
          r_done     <= 1'b1;
          r_rsp_data <= w_load_result;
        end
      end else begin
        r_done      <= 1'b0;
        mem_wb_buff <= w_next_wb;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32_mem_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_rv32_mem_stage
// Brief    : Directed self-checking bench for rv32_mem_stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv32_mem_stage;
  import rv32_types::*;

  logic             clk;
  logic             resetn;
  exec_mem_buffer_t ex;
  mem_wb_buffer_t   mw;
  logic             stop;
  logic             mem_stall;
  rv32_word         wb_bypass;
  logic             dmem_req;
  logic             dmem_we;
  rv32_word         dmem_addr;
  rv32_word         dmem_wdata;
  logic [3:0]       dmem_be;
  logic             dmem_ready;
  logic             dmem_rvalid;
  rv32_word         dmem_rdata;
  logic             misaligned;

  int n_checks = 0;
  int n_fails  = 0;

  rv32_mem_stage dut (
    .clk           (clk),
    .resetn        (resetn),
    .exec_mem_buff (ex),
    .mem_wb_buff   (mw),
    .stop          (stop),
    .mem_stall     (mem_stall),
    .wb_bypass     (wb_bypass),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_ready    (dmem_ready),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .misaligned    (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input mem_op_t op, input rv32_word addr, input rv32_word data,
                        input rv32_word pc);
    ex.instr                       = 32'hA000_0000 ^ pc;
    ex.pc                          = pc;
    ex.decoded_instr.mem_op        = op;
    ex.decoded_instr.wb_result_src = (op >= SB) ? WB_STORE : (op != MEM_NONE) ? WB_MEM : WB_ALU;
    ex.decoded_instr.rd            = 5'd7;
    ex.decoded_instr.reg_write     = (op < SB);
    ex.mem_addr                    = addr;
    ex.wb_result                   = data;
  endtask

  // Load with ready in the request cycle and rvalid one cycle later.
  task automatic run_load(input string tag, input mem_op_t op, input rv32_word addr,
                          input rv32_word rdata, input rv32_word exp, input rv32_word pc);
    set_op(op, addr, 32'h0, pc);
    dmem_ready  = 1'b1;
    dmem_rvalid = 1'b0;
    #1;
    check_val({tag, "_req"},   32'(dmem_req),   32'd1);
    check_val({tag, "_addr"},  dmem_addr,       {addr[31:2], 2'b00});
    check_val({tag, "_stall"}, 32'(mem_stall),  32'd1);
    tick();
    check_val({tag, "_bubble"}, mw.instr, RV_NOP);
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    check_val({tag, "_rsp_stall"}, 32'(mem_stall), 32'd0);
    check_val({tag, "_rsp_req"},   32'(dmem_req),  32'd0);
    tick();
    dmem_rvalid = 1'b0;
    check_val({tag, "_result"}, mw.wb_result, exp);
    check_val({tag, "_pc"},     mw.pc,        pc);
  endtask

  initial begin
    int stall_cnt;
    resetn      = 1'b0;
    stop        = 1'b0;
    dmem_ready  = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    set_op(MEM_NONE, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    check_val("rst_instr",  mw.instr,                 RV_NOP);
    check_val("rst_pc",     mw.pc,                    32'h0);
    check_val("rst_ctrl",   32'(mw.decoded_instr),    32'(create_nop_ctrl()));
    check_val("rst_bypass", wb_bypass,                32'h0);
    check_val("rst_req",    32'(dmem_req),            32'd0);
    check_val("rst_stall",  32'(mem_stall),           32'd0);
    check_val("rst_misal",  32'(misaligned),          32'd0);
    resetn = 1'b1;

    run_load("lb",  LB,  32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80, 32'h100);
    run_load("lbu", LBU, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080, 32'h104);
    run_load("lhu", LHU, 32'h0000_1002, 32'h9876_0000, 32'h0000_9876, 32'h108);

    // Stores with ready high complete in one cycle.
    set_op(SH, 32'h0000_2002, 32'h1234_ABCD, 32'h10C);
    dmem_ready = 1'b1;
    #1;
    check_val("sh_be",    32'(dmem_be),   32'hC);
    check_val("sh_wdata", dmem_wdata,     32'hABCD_ABCD);
    check_val("sh_we",    32'(dmem_we),   32'd1);
    check_val("sh_stall", 32'(mem_stall), 32'd0);
    check_val("sh_addr",  dmem_addr,      32'h0000_2000);
    tick();
    check_val("sh_wb_instr", mw.instr, 32'hA000_0000 ^ 32'h10C);
    set_op(SB, 32'h0000_2001, 32'h0000_005A, 32'h110);
    #1;
    check_val("sb_be",    32'(dmem_be), 32'h2);
    check_val("sb_wdata", dmem_wdata,   32'h5A5A_5A5A);
    tick();
    set_op(SW, 32'h0000_2004, 32'hCAFE_F00D, 32'h114);
    #1;
    check_val("sw_be",    32'(dmem_be), 32'hF);
    check_val("sw_wdata", dmem_wdata,   32'hCAFE_F00D);
    tick();

    // LW with ready low three cycles, rvalid two cycles after accept.
    set_op(LW, 32'h0000_4008, 32'h0, 32'h118);
    dmem_ready = 1'b0;
    stall_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      dmem_ready  = (i == 3);
      dmem_rvalid = (i == 5);
      dmem_rdata  = (i == 5) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      if (i < 4) begin
        check_val("lw_req_held", 32'(dmem_req), 32'd1);
        check_val("lw_addr_held", dmem_addr, 32'h0000_4008);
      end
      if (mem_stall) stall_cnt++;
      tick();
      if (i < 5) check_val("lw_bubble", mw.instr, RV_NOP);
    end
    dmem_rvalid = 1'b0;
    check_val("lw_stall_cycles", 32'(stall_cnt), 32'd5);
    check_val("lw_result", mw.wb_result, 32'hDEAD_BEEF);
    check_val("lw_bypass", wb_bypass,    32'hDEAD_BEEF);

    // Misaligned halfword: no request, NOP to WB.
    set_op(LH, 32'h0000_3001, 32'h0, 32'h11C);
    dmem_ready = 1'b1;
    #1;
    check_val("mis_flag",  32'(misaligned), 32'd1);
    check_val("mis_req",   32'(dmem_req),   32'd0);
    check_val("mis_stall", 32'(mem_stall),  32'd0);
    tick();
    check_val("mis_wb_instr", mw.instr, RV_NOP);
    check_val("mis_wb_ctrl",  32'(mw.decoded_instr), 32'(create_nop_ctrl()));
    set_op(MEM_NONE, 32'h0, 32'h0000_0055, 32'h120);
    #1;
    check_val("alu_misal", 32'(misaligned), 32'd0);
    check_val("alu_req",   32'(dmem_req),   32'd0);
    tick();
    check_val("alu_result", mw.wb_result, 32'h0000_0055);
    check_val("alu_bypass", wb_bypass,    32'h0000_0055);

    // Load response arrives while stopped; writeback happens on release.
    set_op(LH, 32'h0000_5002, 32'h0, 32'h124);
    dmem_ready = 1'b1;
    #1;
    check_val("stp_req", 32'(dmem_req), 32'd1);
    tick();
    stop        = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBEEF_1234;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_val("stp_no_reissue", 32'(dmem_req), 32'd0);
      check_val("stp_hold_instr", mw.instr,      RV_NOP);
      check_val("stp_hold_res",   mw.wb_result,  32'h0);
      tick();
    end
    stop = 1'b0;
    #1;
    check_val("stp_rel_req",   32'(dmem_req),  32'd0);
    check_val("stp_rel_stall", 32'(mem_stall), 32'd0);
    tick();
    check_val("stp_result", mw.wb_result, 32'hFFFF_BEEF);
    check_val("stp_pc",     mw.pc,        32'h124);

    // Reset while waiting for a load; the stale response is ignored.
    set_op(LW, 32'h0000_6000, 32'h0, 32'h128);
    dmem_ready = 1'b1;
    tick();
    resetn = 1'b0;
    tick();
    check_val("rmid_instr", mw.instr, RV_NOP);
    resetn = 1'b1;
    set_op(MEM_NONE, 32'h0, 32'h0000_0077, 32'h12C);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    #1;
    check_val("rmid_req", 32'(dmem_req), 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    check_val("rmid_result", mw.wb_result, 32'h0000_0077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
